// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution / prediction block.
package branch_pkg;

   localparam int unsigned DEFAULT_DEPTH = 16;
   localparam int unsigned XLEN          = 32;
   localparam int unsigned TAG_MAX_W     = 30;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   // Tag is stored zero-extended to the widest possible tag so the struct
   // does not depend on the table depth.
   typedef struct packed {
      logic                   valid;
      logic [TAG_MAX_W-1:0]   tag;
      logic [XLEN-1:0]        target;
      ctr_e                   ctr;
   } btb_entry_t;

   localparam btb_entry_t BTB_ENTRY_RESET = '{
      valid:  1'b0,
      tag:    '0,
      target: '0,
      ctr:    CTR_WNT
   };

   // Saturating step of the 2-bit direction counter toward the outcome.
   function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
      ctr_e nxt;
      nxt = cur;
      unique case (cur)
         CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/br_pred_table.sv
// Direct-mapped BTB storage: two async read ports, one sync write port,
// asynchronous clear. Reads return pre-write contents in the write cycle.
module br_pred_table
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [IDX_W-1:0] i_rd0_idx,
   output btb_entry_t       o_rd0_entry,
   input  logic [IDX_W-1:0] i_rd1_idx,
   output btb_entry_t       o_rd1_entry,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  btb_entry_t       i_wr_entry
);

   btb_entry_t entries_q [DEPTH];
   btb_entry_t entries_d [DEPTH];

   // Asynchronous read ports.
   assign o_rd0_entry = entries_q[i_rd0_idx];
   assign o_rd1_entry = entries_q[i_rd1_idx];

   // Next-state of the table: single-entry write.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         entries_d[i] = entries_q[i];
      end
      if (i_we) begin
         entries_d[i_wr_idx] = i_wr_entry;
      end
   end

   // Table state with asynchronous clear.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries_q[i] <= BTB_ENTRY_RESET;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution, mispredict redirect, BTB update and statistics.
module branch_ctrl
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_if_pc,
   output logic        o_if_pred_taken,
   output logic [31:0] o_if_pred_target,
   input  logic        i_ex_valid,
   input  logic        i_ex_stall,
   input  logic        i_ex_is_br,
   input  logic        i_ex_is_jmp,
   input  logic [2:0]  i_ex_funct3,
   input  logic [31:0] i_ex_pc,
   input  logic [31:0] i_ex_target,
   input  logic        i_ex_pred_taken,
   input  logic [31:0] i_ex_pred_target,
   output logic        o_br_un,
   input  logic        i_br_less,
   input  logic        i_br_equal,
   output logic        o_flush,
   output logic        o_redirect_valid,
   output logic [31:0] o_redirect_pc,
   output logic [31:0] o_br_cnt,
   output logic [31:0] o_mispred_cnt
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned TAG_W = 30 - IDX_W;

   logic [IDX_W-1:0]     if_idx;
   logic [IDX_W-1:0]     ex_idx;
   logic [TAG_MAX_W-1:0] if_tag;
   logic [TAG_MAX_W-1:0] ex_tag;
   btb_entry_t           if_entry;
   btb_entry_t           ex_entry;
   logic                 if_hit_c;
   logic                 ex_hit_c;
   logic                 br_taken_c;
   logic                 br_legal_c;
   logic                 taken_c;
   logic                 resolve_c;
   logic                 mispred_c;
   logic                 we_c;
   btb_entry_t           wr_entry_c;
   logic [31:0]          br_cnt_q, br_cnt_d;
   logic [31:0]          mispred_cnt_q, mispred_cnt_d;
   logic                 unused_c;

   assign if_idx = i_if_pc[IDX_W+1:2];
   assign ex_idx = i_ex_pc[IDX_W+1:2];
   assign if_tag = TAG_MAX_W'(i_if_pc[31:IDX_W+2]);
   assign ex_tag = TAG_MAX_W'(i_ex_pc[31:IDX_W+2]);
   assign unused_c = ^{i_if_pc[1:0], TAG_W[0]};

   br_pred_table #(
      .DEPTH (DEPTH)
   ) u_table (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_rd0_idx   (if_idx),
      .o_rd0_entry (if_entry),
      .i_rd1_idx   (ex_idx),
      .o_rd1_entry (ex_entry),
      .i_we        (we_c),
      .i_wr_idx    (ex_idx),
      .i_wr_entry  (wr_entry_c)
   );

   // Fetch-side prediction lookup.
   always_comb begin
      if_hit_c         = if_entry.valid && (if_entry.tag == if_tag);
      o_if_pred_taken  = if_hit_c && if_entry.ctr[1];
      o_if_pred_target = o_if_pred_taken ? if_entry.target : 32'd0;
   end

   // Comparator select and conditional-branch outcome decode.
   always_comb begin
      br_taken_c = 1'b0;
      br_legal_c = 1'b0;
      o_br_un    = i_ex_funct3[1];
      case (i_ex_funct3)
         F3_BEQ:  begin br_legal_c = 1'b1; br_taken_c = i_br_equal;  end
         F3_BNE:  begin br_legal_c = 1'b1; br_taken_c = !i_br_equal; end
         F3_BLT,
         F3_BLTU: begin br_legal_c = 1'b1; br_taken_c = i_br_less;   end
         F3_BGE,
         F3_BGEU: begin br_legal_c = 1'b1; br_taken_c = !i_br_less;  end
         default: begin br_legal_c = 1'b0; br_taken_c = 1'b0;        end
      endcase
   end

   // Resolve event, mispredict detection and redirect target.
   always_comb begin
      taken_c   = i_ex_is_jmp || (i_ex_is_br && br_taken_c);
      resolve_c = i_ex_valid && !i_ex_stall &&
                  (i_ex_is_jmp || (i_ex_is_br && br_legal_c));
      mispred_c = resolve_c &&
                  ((taken_c != i_ex_pred_taken) ||
                   (taken_c && (i_ex_pred_target != i_ex_target)));
      o_flush          = mispred_c;
      o_redirect_valid = mispred_c;
      o_redirect_pc    = 32'd0;
      if (mispred_c) begin
         o_redirect_pc = taken_c ? i_ex_target : (i_ex_pc + 32'd4);
      end
   end

   // BTB update request for the resolving instruction.
   always_comb begin
      we_c       = 1'b0;
      wr_entry_c = ex_entry;
      ex_hit_c   = ex_entry.valid && (ex_entry.tag == ex_tag);
      if (resolve_c) begin
         if (i_ex_is_jmp) begin
            we_c       = 1'b1;
            wr_entry_c = '{valid: 1'b1, tag: ex_tag, target: i_ex_target, ctr: CTR_ST};
         end else if (ex_hit_c) begin
            we_c           = 1'b1;
            wr_entry_c.ctr = ctr_step(ex_entry.ctr, taken_c);
            if (taken_c) begin
               wr_entry_c.target = i_ex_target;
            end
         end else if (taken_c) begin
            we_c       = 1'b1;
            wr_entry_c = '{valid: 1'b1, tag: ex_tag, target: i_ex_target, ctr: CTR_WT};
         end
      end
   end

   // Saturating statistics next-state.
   always_comb begin
      br_cnt_d      = br_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (resolve_c && (br_cnt_q != '1)) begin
         br_cnt_d = br_cnt_q + 32'd1;
      end
      if (mispred_c && (mispred_cnt_q != '1)) begin
         mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
   end

   // Statistics registers.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         br_cnt_q      <= br_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign o_br_cnt      = br_cnt_q;
   assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus random traffic
// against a table-of-records reference model.
module tb_branch_ctrl;

   localparam int DEPTH = 16;
   localparam int IDX_W = 4;

   logic        i_clk;
   logic        i_reset;
   logic [31:0] i_if_pc;
   logic        o_if_pred_taken;
   logic [31:0] o_if_pred_target;
   logic        i_ex_valid;
   logic        i_ex_stall;
   logic        i_ex_is_br;
   logic        i_ex_is_jmp;
   logic [2:0]  i_ex_funct3;
   logic [31:0] i_ex_pc;
   logic [31:0] i_ex_target;
   logic        i_ex_pred_taken;
   logic [31:0] i_ex_pred_target;
   logic        o_br_un;
   logic        i_br_less;
   logic        i_br_equal;
   logic        o_flush;
   logic        o_redirect_valid;
   logic [31:0] o_redirect_pc;
   logic [31:0] o_br_cnt;
   logic [31:0] o_mispred_cnt;

   branch_ctrl #(.DEPTH(DEPTH)) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_if_pc          (i_if_pc),
      .o_if_pred_taken  (o_if_pred_taken),
      .o_if_pred_target (o_if_pred_target),
      .i_ex_valid       (i_ex_valid),
      .i_ex_stall       (i_ex_stall),
      .i_ex_is_br       (i_ex_is_br),
      .i_ex_is_jmp      (i_ex_is_jmp),
      .i_ex_funct3      (i_ex_funct3),
      .i_ex_pc          (i_ex_pc),
      .i_ex_target      (i_ex_target),
      .i_ex_pred_taken  (i_ex_pred_taken),
      .i_ex_pred_target (i_ex_pred_target),
      .o_br_un          (o_br_un),
      .i_br_less        (i_br_less),
      .i_br_equal       (i_br_equal),
      .o_flush          (o_flush),
      .o_redirect_valid (o_redirect_valid),
      .o_redirect_pc    (o_redirect_pc),
      .o_br_cnt         (o_br_cnt),
      .o_mispred_cnt    (o_mispred_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: one record per table slot.
   bit          m_valid  [DEPTH];
   logic [31:0] m_tag    [DEPTH];
   logic [31:0] m_target [DEPTH];
   int          m_ctr    [DEPTH];
   logic [31:0] m_br;
   logic [31:0] m_mis;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % DEPTH);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc >> (2 + IDX_W);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
      end
      m_br = 0; m_mis = 0;
   endtask

   task automatic clear_ex();
      i_ex_valid = 0; i_ex_stall = 0; i_ex_is_br = 0; i_ex_is_jmp = 0;
      i_ex_funct3 = 0; i_ex_pc = 0; i_ex_target = 0; i_ex_pred_taken = 0;
      i_ex_pred_target = 0; i_br_less = 0; i_br_equal = 0;
   endtask

   function automatic bit m_pred_taken(input logic [31:0] pc);
      int i = idx_of(pc);
      return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
   endfunction

   function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
      return m_pred_taken(pc) ? m_target[idx_of(pc)] : 32'd0;
   endfunction

   // Compare every output against the model for the current inputs, then
   // advance one clock and apply the architectural effect to the model.
   task automatic step();
      bit          legal, taken, ev, mis, un;
      logic [31:0] rpc;
      int          i;
      #1;
      legal = 1; taken = 0;
      if (i_ex_is_jmp) taken = 1;
      else begin
         case (int'(i_ex_funct3))
            0:       taken = i_br_equal;
            1:       taken = !i_br_equal;
            4, 6:    taken = i_br_less;
            5, 7:    taken = !i_br_less;
            default: legal = 0;
         endcase
      end
      un  = (i_ex_funct3 == 3'd2) || (i_ex_funct3 == 3'd3) ||
            (i_ex_funct3 == 3'd6) || (i_ex_funct3 == 3'd7);
      ev  = i_ex_valid && !i_ex_stall && (i_ex_is_br || i_ex_is_jmp) && legal;
      mis = ev && ((taken != i_ex_pred_taken) || (taken && (i_ex_pred_target != i_ex_target)));
      rpc = taken ? i_ex_target : i_ex_pc + 32'd4;
      check("br_un", o_br_un, un);
      check("flush", o_flush, mis);
      check("redirect_valid", o_redirect_valid, mis);
      if (mis) check("redirect_pc", o_redirect_pc, rpc);
      check("pred_taken", o_if_pred_taken, m_pred_taken(i_if_pc));
      check("pred_target", o_if_pred_target, m_pred_target(i_if_pc));
      check("br_cnt", o_br_cnt, m_br);
      check("mispred_cnt", o_mispred_cnt, m_mis);
      @(posedge i_clk);
      if (ev) begin
         i = idx_of(i_ex_pc);
         if (i_ex_is_jmp) begin
            m_valid[i] = 1; m_tag[i] = tag_of(i_ex_pc); m_target[i] = i_ex_target; m_ctr[i] = 3;
         end else if (m_valid[i] && m_tag[i] == tag_of(i_ex_pc)) begin
            m_ctr[i] = taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                             : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            if (taken) m_target[i] = i_ex_target;
         end else if (taken) begin
            m_valid[i] = 1; m_tag[i] = tag_of(i_ex_pc); m_target[i] = i_ex_target; m_ctr[i] = 2;
         end
         if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
         if (mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      end
      #1;
   endtask

   task automatic branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                         input bit less, input bit eq);
      clear_ex();
      i_ex_valid = 1; i_ex_is_br = 1; i_ex_funct3 = f3; i_ex_pc = pc;
      i_ex_target = tgt; i_br_less = less; i_br_equal = eq;
      i_ex_pred_taken  = m_pred_taken(pc);
      i_ex_pred_target = m_pred_target(pc);
   endtask

   logic [31:0] cnt_save;

   initial begin
      i_reset = 0;
      i_if_pc = 0;
      clear_ex();
      m_reset();
      repeat (2) @(posedge i_clk);
      #1 i_reset = 1;

      // Reset state.
      i_if_pc = 32'h100;
      #1;
      check("rst_pred_taken", o_if_pred_taken, 0);
      check("rst_br_cnt", o_br_cnt, 0);
      check("rst_mispred_cnt", o_mispred_cnt, 0);
      step();

      // BLT signed, taken, predicted not taken.
      branch(3'b100, 32'h40, 32'h20, 1, 0);
      #1;
      check("blt_un", o_br_un, 0);
      check("blt_flush", o_flush, 1);
      check("blt_redirect", o_redirect_pc, 32'h20);
      step();
      clear_ex();
      i_if_pc = 32'h40;
      #1;
      check("blt_lookup_taken", o_if_pred_taken, 1);
      check("blt_lookup_target", o_if_pred_target, 32'h20);
      check("blt_mispred_cnt", o_mispred_cnt, 1);
      step();

      // BGEU not taken after a taken prediction.
      branch(3'b111, 32'h40, 32'h20, 1, 0);
      #1;
      check("bgeu_un", o_br_un, 1);
      check("bgeu_flush", o_flush, 1);
      check("bgeu_redirect", o_redirect_pc, 32'h44);
      step();
      clear_ex();
      #1;
      check("bgeu_lookup_taken", o_if_pred_taken, 0);
      step();

      // Counter saturation at 0x80.
      i_if_pc = 32'h80;
      for (int k = 0; k < 4; k++) begin
         branch(3'b000, 32'h80, 32'h90, 0, 1);
         step();
      end
      clear_ex();
      #1;
      check("sat_taken", o_if_pred_taken, 1);
      check("sat_target", o_if_pred_target, 32'h90);
      branch(3'b000, 32'h80, 32'h90, 0, 0);
      step();
      clear_ex();
      #1;
      check("sat_dec_taken", o_if_pred_taken, 1);
      check("sat_dec_target", o_if_pred_target, 32'h90);
      step();

      // Stall hold then release; illegal funct3.
      cnt_save = m_br;
      i_if_pc = 32'hC0;
      branch(3'b000, 32'hC0, 32'hD0, 0, 1);
      i_ex_stall = 1;
      for (int k = 0; k < 3; k++) begin
         #1 check("stall_flush", o_flush, 0);
         step();
      end
      check("stall_br_cnt", o_br_cnt, cnt_save);
      i_ex_stall = 0;
      #1 check("release_flush", o_flush, 1);
      step();
      check("release_br_cnt", o_br_cnt, cnt_save + 1);
      branch(3'b010, 32'h140, 32'h150, 1, 1);
      i_ex_pred_taken = 0; i_ex_pred_target = 0;
      step();
      check("illegal_br_cnt", o_br_cnt, cnt_save + 1);

      // JALR target mismatch with concurrent same-index lookup.
      clear_ex();
      i_ex_valid = 1; i_ex_is_jmp = 1; i_ex_pc = 32'h100; i_ex_target = 32'h200;
      step();
      i_if_pc = 32'h100;
      i_ex_pred_taken = 1; i_ex_pred_target = 32'h200; i_ex_target = 32'h300;
      #1;
      check("jalr_redirect", o_redirect_pc, 32'h300);
      check("jalr_old_target", o_if_pred_target, 32'h200);
      step();
      clear_ex();
      #1 check("jalr_new_target", o_if_pred_target, 32'h300);
      step();

      // Reset mid-operation discards the pending update.
      branch(3'b000, 32'h1C4, 32'h1D0, 0, 1);
      i_if_pc = 32'h1C4;
      #2 i_reset = 0;
      m_reset();
      @(posedge i_clk);
      #1 i_reset = 1;
      clear_ex();
      #1;
      check("midrst_taken", o_if_pred_taken, 0);
      check("midrst_br_cnt", o_br_cnt, 0);
      step();

      // Random traffic over a small aliasing PC space.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] pc;
         pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         clear_ex();
         i_if_pc     = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         i_ex_valid  = ($urandom_range(0, 9) != 0);
         i_ex_stall  = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 4) == 0) i_ex_is_jmp = 1;
         else i_ex_is_br = ($urandom_range(0, 7) != 0);
         i_ex_funct3 = 3'($urandom_range(0, 7));
         i_ex_pc     = pc;
         i_ex_target = 32'h1000 + ($urandom_range(0, 3) << 4);
         i_br_less   = 1'($urandom);
         i_br_equal  = 1'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            i_ex_pred_taken  = m_pred_taken(pc);
            i_ex_pred_target = m_pred_target(pc);
         end else begin
            i_ex_pred_taken  = 1'($urandom);
            i_ex_pred_target = i_ex_pred_taken ? 32'h1000 + ($urandom_range(0, 3) << 4) : 32'd0;
         end
         if (!i_ex_is_jmp && (i_ex_funct3 == 3'd2 || i_ex_funct3 == 3'd3)) begin
            i_ex_pred_taken = 0; i_ex_pred_target = 0;
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
